// File: rtl/uart_reg_responder_if.sv
// Byte-level link between uart_fd and the register responder.
// The master side drives received bytes and transmitter status; the slave side answers.
interface uart_reg_responder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        output rx_data, rx_valid, rx_error, tx_busy,
        input  tx_start, tx_data
    );

    modport slave (
        input  rx_data, rx_valid, rx_error, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Host command responder: parses 'W' addr data / 'R' addr frames against a byte register file
// and answers ACK, the register value, or NAK through the UART transmitter.
module uart_reg_responder #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         BAUD_RATE     = 115200,
    parameter int         NUM_REGS      = 16,
    parameter int         TIMEOUT_BYTES = 4,
    parameter logic [7:0] ACK_BYTE      = 8'h06,
    parameter logic [7:0] NAK_BYTE      = 8'h15
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_reg_responder_if.slave     bus,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int         TMO   = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int         TW    = $clog2(TMO + 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_BUSY, WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_BAD} op_t;

    state_t          state, state_next;
    op_t             op;
    logic [7:0]      addr;
    logic [7:0]      data;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      wait_cnt;
    logic            timeout;
    logic            addr_ok;
    logic            busy_rx;
    logic            frame_err_next;
    logic            overrun_next;

    assign timeout = (tmo_cnt == TW'(TMO - 1));
    assign addr_ok = ({1'b0, addr} < 9'(NUM_REGS));
    assign busy_rx = (state == EXEC) || (state == SEND) ||
                     (state == WAIT_BUSY) || (state == WAIT_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        bus.tx_start   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_error) begin
                    frame_err_next = 1'b1;
                end else if (bus.rx_valid) begin
                    state_next = (bus.rx_data == CMD_W || bus.rx_data == CMD_R) ? GET_ADDR : EXEC;
                end
            end
            GET_ADDR: begin
                if (bus.rx_error) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else if (bus.rx_valid) begin
                    state_next = (op == OP_WRITE) ? GET_DATA : EXEC;
                end else if (timeout) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            GET_DATA: begin
                if (bus.rx_error) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else if (bus.rx_valid) begin
                    state_next = EXEC;
                end else if (timeout) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            EXEC: state_next = SEND;
            SEND: begin
                if (!bus.tx_busy) begin
                    bus.tx_start = 1'b1;
                    state_next   = WAIT_BUSY;
                end
            end
            // A transmitter that never acknowledges the start must not hang the responder.
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (wait_cnt == 2'd3) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (busy_rx && bus.rx_valid) overrun_next = 1'b1;
    end

    // NOTE: the register file is reset along with the control state because its reset contents are visible on regs_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_out    <= '0;
            op          <= OP_BAD;
            addr        <= '0;
            data        <= '0;
            bus.tx_data <= '0;
            tmo_cnt     <= '0;
            wait_cnt    <= '0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= frame_err_next;
            overrun   <= overrun_next;

            if ((state == GET_ADDR || state == GET_DATA) && !bus.rx_valid && !bus.rx_error)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;

            if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;
            else                    wait_cnt <= '0;

            case (state)
                IDLE: begin
                    if (bus.rx_valid && !bus.rx_error) begin
                        if (bus.rx_data == CMD_W)      op <= OP_WRITE;
                        else if (bus.rx_data == CMD_R) op <= OP_READ;
                        else                           op <= OP_BAD;
                    end
                end
                GET_ADDR: if (bus.rx_valid && !bus.rx_error) addr <= bus.rx_data;
                GET_DATA: if (bus.rx_valid && !bus.rx_error) data <= bus.rx_data;
                // The read path samples the old value, before this cycle's write lands.
                EXEC: begin
                    if (op == OP_BAD || !addr_ok) begin
                        bus.tx_data <= NAK_BYTE;
                    end else if (op == OP_WRITE) begin
                        regs_out[8*addr +: 8] <= data;
                        bus.tx_data           <= ACK_BYTE;
                    end else begin
                        bus.tx_data <= regs_out[8*addr +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: drives byte frames, models a transmitter that
// raises busy after tx_start, and checks responses, register contents and error pulses.
module tb_uart_reg_responder;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD_RATE = 100;
    localparam int NUM_REGS  = 16;
    localparam int TMO       = 4 * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int BUSY_CYC  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_reg_responder_if bus();
    logic [NUM_REGS*8-1:0] regs_out;
    logic                  frame_err;
    logic                  overrun;

    uart_reg_responder #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD_RATE),
        .NUM_REGS      (NUM_REGS),
        .TIMEOUT_BYTES (4),
        .ACK_BYTE      (8'h06),
        .NAK_BYTE      (8'h15)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .regs_out  (regs_out),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] tx_log[$];
    int         seen = 0;
    int         busy_cnt = 0;
    logic       start_seen = 1'b0;
    logic       busy_en = 1'b1;
    logic       hold_busy = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [127:0] exp_regs = '0;

    assign bus.tx_busy = hold_busy | (busy_cnt != 0);

    // Transmitter model: log each started byte, then hold busy for BUSY_CYC cycles.
    always @(negedge clk) begin
        start_seen <= bus.tx_start;
        if (bus.tx_start) tx_log.push_back(bus.tx_data);
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (overrun)   ov_cnt <= ov_cnt + 1;
    end

    always @(posedge clk) begin
        if (start_seen && busy_en) busy_cnt <= BUSY_CYC;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves rx_valid high for exactly one rising edge.
    task automatic pulse_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] exp);
        int budget;
        budget = 40;
        while (tx_log.size() <= seen && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_count"}, tx_log.size(), seen + 1);
        if (tx_log.size() > seen) check(tag, tx_log[seen], exp);
        seen = tx_log.size();
        tick(BUSY_CYC + 4);
    endtask

    initial begin
        int fe0;
        int ov0;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_regs",      regs_out,     '0);
        check("rst_tx_start",  bus.tx_start, 1'b0);
        check("rst_tx_data",   bus.tx_data,  8'h00);
        check("rst_frame_err", frame_err,    1'b0);
        check("rst_overrun",   overrun,      1'b0);

        // Write 0xA5 to reg 3 with exact latency, then read it back.
        pulse_byte(8'h57);
        pulse_byte(8'h03);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("exec_no_start", bus.tx_start, 1'b0);
        check("exec_reg_old",  regs_out[31:24], 8'h00);
        @(negedge clk);
        check("send_start",    bus.tx_start, 1'b1);
        check("send_ack_data", bus.tx_data, 8'h06);
        check("send_reg_new",  regs_out[31:24], 8'hA5);
        exp_regs[31:24] = 8'hA5;
        expect_resp("w03_ack", 8'h06);
        pulse_byte(8'h52);
        pulse_byte(8'h03);
        expect_resp("r03", 8'hA5);
        check("tx_data_held", bus.tx_data, 8'hA5);
        check("regs_after_w03", regs_out, exp_regs);

        // Unknown command byte.
        pulse_byte(8'h41);
        expect_resp("bad_cmd_nak", 8'h15);
        check("regs_after_bad_cmd", regs_out, exp_regs);
        pulse_byte(8'h52);
        pulse_byte(8'h00);
        expect_resp("r00", 8'h00);

        // Address range boundaries.
        pulse_byte(8'h57);
        pulse_byte(8'h10);
        pulse_byte(8'h55);
        expect_resp("w10_nak", 8'h15);
        check("regs_after_w10", regs_out, exp_regs);
        pulse_byte(8'h52);
        pulse_byte(8'hFF);
        expect_resp("rff_nak", 8'h15);
        pulse_byte(8'h57);
        pulse_byte(8'h0F);
        pulse_byte(8'h3C);
        expect_resp("w0f_ack", 8'h06);
        exp_regs[127:120] = 8'h3C;
        check("regs_after_w0f", regs_out, exp_regs);
        pulse_byte(8'h52);
        pulse_byte(8'h0F);
        expect_resp("r0f", 8'h3C);

        // Inter-byte timeout aborts a partial frame.
        fe0 = fe_cnt;
        pulse_byte(8'h57);
        pulse_byte(8'h02);
        tick(TMO + 10);
        check("tmo_frame_err", fe_cnt - fe0, 1);
        check("tmo_no_tx",     tx_log.size(), seen);
        pulse_byte(8'h52);
        pulse_byte(8'h02);
        expect_resp("r02_after_tmo", 8'h00);

        // Slow but in-time bytes are accepted.
        fe0 = fe_cnt;
        pulse_byte(8'h57);
        tick(TMO / 2);
        pulse_byte(8'h05);
        tick(TMO / 2);
        pulse_byte(8'h77);
        expect_resp("w05_slow_ack", 8'h06);
        exp_regs[47:40] = 8'h77;
        check("regs_after_w05", regs_out, exp_regs);
        check("slow_no_frame_err", fe_cnt - fe0, 0);

        // rx_error mid-frame, then rx_error coincident with rx_valid.
        fe0 = fe_cnt;
        pulse_byte(8'h57);
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_error = 1'b0;
        tick(5);
        check("rxerr_frame_err", fe_cnt - fe0, 1);
        check("rxerr_no_tx",     tx_log.size(), seen);
        pulse_byte(8'h52);
        pulse_byte(8'h00);
        expect_resp("r00_after_rxerr", 8'h00);
        fe0 = fe_cnt;
        pulse_byte(8'h52);
        bus.rx_data  = 8'h01;
        bus.rx_valid = 1'b1;
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        tick(5);
        check("rxerr_prio_frame_err", fe_cnt - fe0, 1);
        check("rxerr_prio_no_tx",     tx_log.size(), seen);

        // Extra byte during the response is dropped with an overrun pulse.
        ov0 = ov_cnt;
        pulse_byte(8'h52);
        pulse_byte(8'h05);
        pulse_byte(8'h99);
        expect_resp("r05_overrun", 8'h77);
        tick(4);
        check("overrun_pulse",  ov_cnt - ov0, 1);
        check("overrun_single", tx_log.size(), seen);

        // SEND holds off while the transmitter is busy; rx_error there is ignored.
        fe0 = fe_cnt;
        hold_busy = 1'b1;
        pulse_byte(8'h52);
        pulse_byte(8'h03);
        tick(4);
        check("hold_no_start", bus.tx_start, 1'b0);
        check("hold_no_tx",    tx_log.size(), seen);
        bus.rx_error = 1'b1;
        @(negedge clk);
        bus.rx_error = 1'b0;
        hold_busy = 1'b0;
        expect_resp("r03_after_hold", 8'hA5);
        check("hold_rxerr_ignored", fe_cnt - fe0, 0);

        // Transmitter never raises busy: give up after four cycles.
        busy_en = 1'b0;
        fe0 = fe_cnt;
        pulse_byte(8'h52);
        pulse_byte(8'h03);
        expect_resp("r03_nobusy", 8'hA5);
        tick(4);
        check("nobusy_frame_err", fe_cnt - fe0, 1);
        busy_en = 1'b1;
        pulse_byte(8'h52);
        pulse_byte(8'h0F);
        expect_resp("r0f_recover", 8'h3C);

        // Reset in the middle of a response.
        pulse_byte(8'h52);
        pulse_byte(8'h03);
        @(negedge clk);
        check("pre_rst_start", bus.tx_start, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_start",  bus.tx_start, 1'b0);
        check("mid_rst_tx_data",   bus.tx_data,  8'h00);
        check("mid_rst_regs",      regs_out,     '0);
        check("mid_rst_frame_err", frame_err,    1'b0);
        check("mid_rst_overrun",   overrun,      1'b0);
        tick(2);
        rst = 1'b0;
        exp_regs = '0;
        tick(BUSY_CYC + 3);
        seen = tx_log.size();
        pulse_byte(8'h52);
        pulse_byte(8'h03);
        expect_resp("r03_after_rst", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
